// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter shared types: widths, FSM state and owner codes.
// Optional loader lock is enabled with MEM_ARBITER_LOCK_EN.
package mem_arbiter_pkg;

    localparam int ADDR_WIDTH = 5;
    localparam int DATA_WIDTH = 8;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_XFER = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_e;

    typedef enum logic {
        ARB_OWN_CPU = 1'b0,
        ARB_OWN_LDR = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester req/ack handshake bundle for mem_arbiter.
// master = requester side, slave = arbiter side.
interface mem_arbiter_if #(
    parameter int AW = mem_arbiter_pkg::ADDR_WIDTH,
    parameter int DW = mem_arbiter_pkg::DATA_WIDTH
);

    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ack;

    modport master (
        output req, we, addr, wdata,
        input  ack
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack
    );

endinterface

// File: rtl/arb_starve_ctr.sv
// Saturating count of CPU grants made while the loader waits.
// force_ldr is raised once the count reaches LIMIT.
module arb_starve_ctr #(
    parameter int W     = 4,
    parameter int LIMIT = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         upd,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         force_ldr
);

    localparam logic [W-1:0] LIM = W'(LIMIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (upd) begin
            if (!inc)
                cnt <= '0;
            else if (cnt != LIM)
                cnt <= cnt + 1'b1;
        end
    end

    assign force_ldr = (cnt == LIM);

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester single-port memory arbiter, CPU priority with starvation guard.
// Define MEM_ARBITER_LOCK_EN to add the ldr_lock input.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = ADDR_WIDTH,
    parameter int DATA_W       = DATA_WIDTH,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    mem_arbiter_if.slave      cpu,
    mem_arbiter_if.slave      ldr,
`ifdef MEM_ARBITER_LOCK_EN
    input  logic              ldr_lock,
`endif
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    arb_state_e        state, state_nxt;
    arb_owner_e        owner, owner_nxt;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              lat_we;
    logic [CNT_W-1:0]  starve_cnt;
    logic              force_ldr;
    logic              lock_act;
    logic              ldr_win;
    logic              cpu_win;
    logic              grant;
    logic              idle;

`ifdef MEM_ARBITER_LOCK_EN
    assign lock_act = ldr_lock && (owner == ARB_OWN_LDR);
`else
    assign lock_act = 1'b0;
`endif

    assign idle = (state == ARB_IDLE);

    // Under lock the CPU is never picked and the counter is frozen.
    always_comb begin
        ldr_win = 1'b0;
        cpu_win = 1'b0;
        unique case (1'b1)
            lock_act: ldr_win = ldr.req;
            default: begin
                ldr_win = ldr.req && (!cpu.req || force_ldr);
                cpu_win = cpu.req && !ldr_win;
            end
        endcase
    end

    assign grant = idle && (ldr_win || cpu_win);

    arb_starve_ctr #(
        .W     (CNT_W),
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk       (clk),
        .rst       (rst),
        .upd       (idle && !lock_act),
        .inc       (cpu_win && ldr.req),
        .cnt       (starve_cnt),
        .force_ldr (force_ldr)
    );

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        unique case (state)
            ARB_IDLE: begin
                if (grant) begin
                    state_nxt = ARB_XFER;
                    owner_nxt = ldr_win ? ARB_OWN_LDR
                                        : ARB_OWN_CPU;
                end
            end
            ARB_XFER: state_nxt = ARB_DONE;
            ARB_DONE: state_nxt = ARB_IDLE;
            default:  state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ARB_IDLE;
            owner <= ARB_OWN_CPU;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_we    <= 1'b0;
            rdata     <= '0;
        end else begin
            if (grant) begin
                lat_addr  <= ldr_win ? ldr.addr  : cpu.addr;
                lat_wdata <= ldr_win ? ldr.wdata : cpu.wdata;
                lat_we    <= ldr_win ? ldr.we    : cpu.we;
            end
            if (state == ARB_XFER && !lat_we)
                rdata <= mem_rdata;
        end
    end

    logic xfer;
    assign xfer = (state == ARB_XFER);

    assign mem_addr  = xfer ? lat_addr  : '0;
    assign mem_wdata = xfer ? lat_wdata : '0;
    assign mem_wr    = xfer && lat_we;
    assign mem_rd    = xfer && !lat_we;
    assign busy      = !idle;

    assign cpu.ack = (state == ARB_DONE)
                  && (owner == ARB_OWN_CPU);
    assign ldr.ack = (state == ARB_DONE)
                  && (owner == ARB_OWN_LDR);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
// Define MEM_ARBITER_LOCK_EN to also exercise the loader lock.
module tb_mem_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] rdata;
    logic [4:0] mem_addr;
    logic       mem_rd;
    logic       mem_wr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       busy;
`ifdef MEM_ARBITER_LOCK_EN
    logic       ldr_lock;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int wr_cnt = 0;

    logic [7:0] mem [32];

    mem_arbiter_if cpu_if ();
    mem_arbiter_if ldr_if ();

    mem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .cpu       (cpu_if.slave),
        .ldr       (ldr_if.slave),
`ifdef MEM_ARBITER_LOCK_EN
        .ldr_lock  (ldr_lock),
`endif
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem_rd ? mem[mem_addr] : 8'h00;

    always @(posedge clk) begin
        if (!rst) begin
            mem[3]  <= 8'hA5;
            mem[1]  <= 8'h11;
            mem[2]  <= 8'h22;
            mem[16] <= 8'h00;
        end else if (mem_wr) begin
            mem[mem_addr] <= mem_wdata;
        end
        if (mem_wr)
            wr_cnt <= wr_cnt + 1;
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int wr0;

    initial begin
        rst          = 1'b0;
        cpu_if.req   = 1'b0;
        cpu_if.we    = 1'b0;
        cpu_if.addr  = '0;
        cpu_if.wdata = '0;
        ldr_if.req   = 1'b0;
        ldr_if.we    = 1'b0;
        ldr_if.addr  = '0;
        ldr_if.wdata = '0;
`ifdef MEM_ARBITER_LOCK_EN
        ldr_lock     = 1'b0;
`endif
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_rd", mem_rd, 0);
        chk("rst_wr", mem_wr, 0);
        chk("rst_cack", cpu_if.ack, 0);
        chk("rst_lack", ldr_if.ack, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_addr", mem_addr, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        step();

        // CPU read alone
        cpu_if.req  = 1'b1;
        cpu_if.we   = 1'b0;
        cpu_if.addr = 5'h03;
        step();
        chk("t1_rd", mem_rd, 1);
        chk("t1_addr", mem_addr, 5'h03);
        chk("t1_busy", busy, 1);
        chk("t1_cack_x", cpu_if.ack, 0);
        step();
        chk("t1_cack", cpu_if.ack, 1);
        chk("t1_rdata", rdata, 8'hA5);
        chk("t1_rd_d", mem_rd, 0);
        cpu_if.req = 1'b0;
        step();
        chk("t1_idle", busy, 0);
        chk("t1_cack_i", cpu_if.ack, 0);

        // loader write, then CPU read back
        wr0 = wr_cnt;
        ldr_if.req   = 1'b1;
        ldr_if.we    = 1'b1;
        ldr_if.addr  = 5'h10;
        ldr_if.wdata = 8'h3C;
        step();
        chk("t2_wr", mem_wr, 1);
        chk("t2_rd", mem_rd, 0);
        chk("t2_addr", mem_addr, 5'h10);
        chk("t2_wdata", mem_wdata, 8'h3C);
        ldr_if.req = 1'b0;
        step();
        chk("t2_lack", ldr_if.ack, 1);
        chk("t2_cack", cpu_if.ack, 0);
        chk("t2_wr_d", mem_wr, 0);
        step();
        chk("t2_lack_i", ldr_if.ack, 0);
        cpu_if.req  = 1'b1;
        cpu_if.we   = 1'b0;
        cpu_if.addr = 5'h10;
        step();
        chk("t2_raddr", mem_addr, 5'h10);
        step();
        chk("t2_cack2", cpu_if.ack, 1);
        chk("t2_rdata", rdata, 8'h3C);
        chk("t2_wrcnt", wr_cnt - wr0, 1);
        cpu_if.req = 1'b0;
        step();

        // contention: CPU x4 then loader
        cpu_if.req  = 1'b1;
        cpu_if.we   = 1'b0;
        cpu_if.addr = 5'h01;
        ldr_if.req  = 1'b1;
        ldr_if.we   = 1'b0;
        ldr_if.addr = 5'h02;
        for (int i = 1; i <= 17; i++) begin
            step();
            chk($sformatf("t3_cack%0d", i), cpu_if.ack,
                (i % 3 == 2) && (i != 14));
            chk($sformatf("t3_lack%0d", i), ldr_if.ack,
                i == 14);
            if (i == 13)
                chk("t3_laddr", mem_addr, 5'h02);
        end
        chk("t3_rdata", rdata, 8'h11);
        cpu_if.req = 1'b0;
        ldr_if.req = 1'b0;
        step();

        // inputs ignored mid-transaction
        cpu_if.req  = 1'b1;
        cpu_if.we   = 1'b0;
        cpu_if.addr = 5'h01;
        step();
        chk("t4_addr", mem_addr, 5'h01);
        cpu_if.addr = 5'h02;
        ldr_if.req  = 1'b1;
        ldr_if.we   = 1'b0;
        ldr_if.addr = 5'h04;
        #1;
        chk("t4_addr_h", mem_addr, 5'h01);
        step();
        chk("t4_cack", cpu_if.ack, 1);
        chk("t4_lack", ldr_if.ack, 0);
        chk("t4_rdata", rdata, 8'h11);
        cpu_if.req = 1'b0;
        step();
        chk("t4_idle", busy, 0);
        step();
        chk("t4_laddr", mem_addr, 5'h04);
        ldr_if.req = 1'b0;
        step();
        chk("t4_lack2", ldr_if.ack, 1);
        step();

        // async reset during a write
        wr0 = wr_cnt;
        cpu_if.req   = 1'b1;
        cpu_if.we    = 1'b1;
        cpu_if.addr  = 5'h07;
        cpu_if.wdata = 8'h55;
        step();
        chk("t5_wr", mem_wr, 1);
        #2 rst = 1'b0;
        #1;
        chk("t5_wr_r", mem_wr, 0);
        chk("t5_busy_r", busy, 0);
        chk("t5_cack_r", cpu_if.ack, 0);
        step();
        chk("t5_nowr", wr_cnt - wr0, 0);
        rst = 1'b1;
        cpu_if.we   = 1'b0;
        cpu_if.addr = 5'h03;
        ldr_if.req  = 1'b1;
        ldr_if.we   = 1'b0;
        ldr_if.addr = 5'h04;
        step();
        chk("t5_addr", mem_addr, 5'h03);
        step();
        chk("t5_cack", cpu_if.ack, 1);
        chk("t5_lack", ldr_if.ack, 0);
        cpu_if.req = 1'b0;
        ldr_if.req = 1'b0;
        step();

`ifdef MEM_ARBITER_LOCK_EN
        // loader lock holds off the CPU
        ldr_lock     = 1'b1;
        ldr_if.req   = 1'b1;
        ldr_if.we    = 1'b1;
        ldr_if.addr  = 5'h08;
        ldr_if.wdata = 8'h77;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 1) begin
                cpu_if.req  = 1'b1;
                cpu_if.we   = 1'b0;
                cpu_if.addr = 5'h09;
            end
            chk($sformatf("t6_lack%0d", i), ldr_if.ack,
                (i % 3 == 2) && (i <= 17));
            chk($sformatf("t6_cack%0d", i), cpu_if.ack,
                i == 20);
            if (i == 17)
                ldr_lock = 1'b0;
            if (i == 19)
                chk("t6_caddr", mem_addr, 5'h09);
        end
        cpu_if.req = 1'b0;
        ldr_if.req = 1'b0;
        step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
